// File: rtl/nn_layer.sv
// rtl/nn_layer.sv - fully connected layer: serial MAC over SIZE samples, saturating ReLU, serial output
module nn_layer #(
    parameter int SIZE  = 3,
    parameter int DEPTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   input_select,
    input  logic [DEPTH-1:0]                       x,
    input  logic [SIZE-1:0][SIZE-1:0][DEPTH-1:0]   w,
    output logic [DEPTH-1:0]                       y
);

    localparam int CW   = $clog2(SIZE);
    localparam int PW   = 2 * DEPTH;
    localparam int ACCW = PW + CW;

    localparam logic [CW-1:0]          CNT_LAST = CW'(SIZE - 1);
    localparam logic signed [ACCW-1:0] ACT_MAX  = {{(ACCW-DEPTH+1){1'b0}}, {(DEPTH-1){1'b1}}};

    logic [CW-1:0]          cnt_q;
    logic signed [ACCW-1:0] acc_q [SIZE];
    logic [DEPTH-1:0]       out_q [SIZE];

    logic signed [DEPTH-1:0] sample;
    logic signed [PW-1:0]    prod   [SIZE];
    logic signed [ACCW-1:0]  sum_d  [SIZE];
    logic [DEPTH-1:0]        act_d  [SIZE];

    // y is the head of the output shift register; feedback reads the same word
    assign y      = out_q[0];
    assign sample = input_select ? $signed(x) : $signed(out_q[0]);

    // Per-neuron product of this edge's weight column with the sample, running sum and ReLU clamp
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            prod[i]  = $signed(w[i][cnt_q]) * sample;
            sum_d[i] = acc_q[i] + {{CW{prod[i][PW-1]}}, prod[i]};
            act_d[i] = '0;
            if (sum_d[i][ACCW-1]) begin
                act_d[i] = '0;
            end else if (sum_d[i] > ACT_MAX) begin
                act_d[i] = ACT_MAX[DEPTH-1:0];
            end else begin
                act_d[i] = sum_d[i][DEPTH-1:0];
            end
        end
    end

    // Accumulate during the frame; on the last sample load activations and clear accumulators
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                acc_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                acc_q[i] <= '0;
                out_q[i] <= act_d[i];
            end
        end else begin
            cnt_q <= cnt_q + CW'(1);
            for (int i = 0; i < SIZE; i++) begin
                acc_q[i] <= sum_d[i];
            end
            for (int k = 0; k < SIZE - 1; k++) begin
                out_q[k] <= out_q[k+1];
            end
            out_q[SIZE-1] <= '0;
        end
    end

endmodule

// File: tb/tb_nn_layer.sv
// tb/tb_nn_layer.sv - scoreboard bench for nn_layer (frame-level matrix model, queued expected words)
module tb_nn_layer;

    localparam int SIZE  = 3;
    localparam int DEPTH = 16;
    localparam int AMAX  = 32767;

    logic                                 clk = 1'b0;
    logic                                 rst = 1'b0;
    logic                                 input_select = 1'b1;
    logic signed [DEPTH-1:0]              x = '0;
    logic [SIZE-1:0][SIZE-1:0][DEPTH-1:0] w;
    logic signed [DEPTH-1:0]              y;

    int W [SIZE][SIZE];
    int fbuf [SIZE];
    int idx;
    int cyc;
    int exp_q [$];
    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    nn_layer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_select (input_select),
        .x            (x),
        .w            (w),
        .y            (y)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_w();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                w[i][j] = DEPTH'(W[i][j]);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                W[i][j] = v;
    endtask

    task automatic set_identity();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                W[i][j] = (i == j) ? 1 : 0;
    endtask

    function automatic int relu_sat(input longint v);
        if (v < 0) return 0;
        if (v > AMAX) return AMAX;
        return int'(v);
    endfunction

    task automatic restart_model();
        idx = 0;
        exp_q.delete();
        for (int k = 0; k < SIZE; k++) exp_q.push_back(0);
    endtask

    // One clock: compare current y with the scoreboard head, record the sample, advance the clock
    task automatic step(input bit sel, input int xv);
        int     e;
        int     s;
        longint acc;
        if (idx == 0) set_w();
        input_select = sel;
        x = DEPTH'(xv);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty cycle %0d got %0d expected queued word", cyc, y);
            e = 0;
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("y_cyc%0d", cyc), int'(y), e);
        end
        s = sel ? xv : e;
        fbuf[idx] = s;
        idx++;
        if (idx == SIZE) begin
            for (int i = 0; i < SIZE; i++) begin
                acc = 0;
                for (int j = 0; j < SIZE; j++) acc += longint'(W[i][j]) * longint'(fbuf[j]);
                exp_q.push_back(relu_sat(acc));
            end
            idx = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit sel, input int a, input int b, input int c);
        step(sel, a);
        step(sel, b);
        step(sel, c);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        set_identity();
        set_w();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", int'(y), 0);
        rst = 1'b1;
        restart_model();

        // identity passthrough, one frame of latency
        frame(1, 1, 2, 3);
        frame(1, 4, 5, 6);
        // all ones: every neuron sums the frame
        set_all(1);
        frame(1, 1, 2, 3);
        // row 1 negated: ReLU clamps neuron 1
        set_identity();
        for (int j = 0; j < SIZE; j++) W[1][j] = -1;
        frame(1, 1, 2, 3);
        // positive saturation and negative clamp
        set_all(200);
        frame(1, 200, 0, 0);
        frame(1, -200, 0, 0);
        // recirculation with identity weights; x carries junk that must be ignored
        set_identity();
        frame(1, 7, 8, 9);
        for (int f = 0; f < 4; f++) frame(0, 111, -222, 333);
        // row 0 doubled: neuron 0 grows each frame and saturates
        W[0][0] = 2;
        for (int f = 0; f < 15; f++) frame(0, 5, 5, 5);

        // asynchronous reset after sample 1 of a frame
        set_identity();
        frame(1, 10, 20, 30);
        step(1, 40);
        step(1, 50);
        rst = 1'b0;
        #1;
        chk("async_reset_y", int'(y), 0);
        @(posedge clk);
        #1;
        chk("held_reset_y", int'(y), 0);
        rst = 1'b1;
        restart_model();
        frame(1, 1, 2, 3);
        frame(1, 0, 0, 0);

        // randomized weights, samples and source selection including mixed frames
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    W[i][j] = int'($urandom_range(200)) - 100;
            for (int k = 0; k < SIZE; k++)
                step(1'($urandom_range(1)), int'($urandom_range(4000)) - 2000);
        end
        frame(1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nn_layer.md
# nn_layer

Fully connected neural-network layer of SIZE neurons with serial (one-word-per-clock) input and output streams. Each frame of SIZE input words is multiply-accumulated against a SIZE×SIZE weight matrix, passed through a saturating ReLU, and streamed out serially during the following frame. An input mux lets the layer consume either an external stream or its own output stream, so chained layers can be evaluated by recirculation.

## Interface
- SIZE, default 3: number of neurons, equal to the number of inputs per frame (≥2).
- DEPTH, default 16: word width of samples, weights and outputs (signed two's complement integers).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- input_select  input  1  1: sample source is x; 0: sample source is y (feedback).
- x  input  DEPTH  external serial input sample, signed.
- w  input  SIZE×SIZE×DEPTH  weight matrix, packed [SIZE][SIZE][DEPTH]; w[i][j] is the weight of neuron i for input j, signed; must be held stable while in use.
- y  output  DEPTH  serial output sample, signed, registered.

## Operation
- State:
  - sample counter cnt, 0..SIZE-1;
  - SIZE accumulators acc[i], each 2·DEPTH+clog2(SIZE) bits signed;
  - output shift register out_reg[0..SIZE-1], DEPTH bits each.
- y = out_reg[0].
- Sample each edge: s = input_select ? x : y, where y is the value before the edge.
- Every edge with cnt < SIZE-1:
  - acc[i] += w[i][cnt]·s for all i, using a full 2·DEPTH signed product;
  - out_reg shifts toward index 0: out_reg[k] <= out_reg[k+1], out_reg[SIZE-1] <= 0;
  - cnt += 1.
- Edge with cnt == SIZE-1 (end of frame):
  - out_reg[i] <= act(acc[i] + w[i][SIZE-1]·s);
  - acc[i] <= 0;
  - cnt <= 0.
  - This load takes priority over the shift.
- Activation act(v): result is 0 if v < 0; 2^(DEPTH-1)-1 if v > 2^(DEPTH-1)-1; otherwise v. Integer arithmetic only, no fractional scaling.
- input_select may change on any edge; it affects only the sample taken at that edge. Mixed frames are legal.
- With input_select=0, the output of frame f is the input of frame f+1, sample k = neuron k. This is the same weights applied repeatedly.
- No handshake: one sample is consumed and one output word is presented every clock, unconditionally.

## Timing
- Reset (rst=0, asynchronous) forces cnt=0, all acc=0, all out_reg=0, so y=0 immediately. Reset is held while rst=0.
- Edges are numbered from 0, starting at the first rising edge with rst=1. Sample j of frame f is captured at edge SIZE·f+j.
- The results of frame f are loaded at edge SIZE·f+SIZE-1.
- After that load, y shows neuron k of frame f for the cycle following edge SIZE·(f+1)+k-1, i.e. while sample k of frame f+1 is being captured.
- Latency: neuron 0 of a frame appears on y 1 cycle after that frame's last sample edge.
- Before the first frame completes, y=0. After neuron SIZE-1, trailing shifts insert 0 only if the next load has not occurred; loads always occur every SIZE edges, so this does not happen in steady state.
- Reset mid-frame discards the partial accumulation. The next frame starts at sample 0 on the first edge after release.
- Overflow inside acc is impossible within one frame given the accumulator width. Saturation happens only at act.

## Test plan
- Identity weights (w[i][i]=1, else 0), SIZE=3, DEPTH=16, input_select=1, x=1,2,3,4,5,6 → y=0,0,0 during frame 0, then y=1,2,3 during frame 1, then 4,5,6 during frame 2.
- All weights 1, x=1,2,3 → y=6,6,6 during the next frame.
- w row 1 all -1, other rows identity, x=1,2,3 → y=1,0,3 (ReLU clamps neuron 1).
- All weights 200, x=200,0,0 → y=32767 on all three outputs (positive saturation); x=-200,0,0 → y=0,0,0.
- Identity weights, frame 0 from x=7,8,9, then input_select=0 → y recirculates 7,8,9 every frame indefinitely. With row 0 doubled, neuron 0 doubles each frame until it saturates at 32767.
- Assert rst=0 after sample 1 of a frame → y=0 immediately. After release, x=1,2,3 with identity weights → y=1,2,3 in the following frame, with no contribution from pre-reset samples.
